// File: rtl/reg_share_arbiter.sv
// Round-robin arbiter that shares one holding register between N_REQ requesters.
// A grant lasts one cycle, and the granted requester's opcode is applied at the completing edge.
module reg_share_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] SET_VAL = 32'h0000_0001
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [2*N_REQ-1:0]     op,
  input  logic [WIDTH*N_REQ-1:0] din,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       ack,
  output logic                   busy,
  output logic [WIDTH-1:0]       dout,
  output logic [2:0]             owner
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic {StIdle, StGrant} state_e;

  state_e           state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [2:0]       owner_q, owner_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] win_q, win_d;

  logic [N_REQ-1:0] eligible;
  logic             found;
  logic [IDX_W-1:0] pick;
  logic [IDX_W-1:0] cand;
  logic [1:0]       cur_op;
  logic [WIDTH-1:0] cur_din;

  // The requester acked this cycle still holds req high; keep it out of this arbitration.
  assign eligible = req & ~ack_q;

  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = IDX_W'((int'(ptr_q) + k) % N_REQ);
      if (!found && eligible[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  assign cur_op  = op[2*int'(win_q) +: 2];
  assign cur_din = din[WIDTH*int'(win_q) +: WIDTH];

  always_comb begin
    state_d = state_q;
    gnt_d   = '0;
    ack_d   = '0;
    dout_d  = dout_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          win_d   = pick;
          gnt_d   = N_REQ'(1) << pick;
          state_d = StGrant;
        end
      end
      StGrant: begin
        state_d = StIdle;
        // A requester that dropped req while granted aborts: no write, no ack, pointer kept.
        if (req[win_q]) begin
          case (cur_op)
            2'b00:   dout_d = cur_din;
            2'b01:   dout_d = '0;
            2'b10:   dout_d = SET_VAL;
            default: dout_d = dout_q;
          endcase
          ack_d   = N_REQ'(1) << win_q;
          owner_d = 3'(win_q);
          ptr_d   = IDX_W'((int'(win_q) + 1) % N_REQ);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      ack_q   <= '0;
      dout_q  <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      win_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      dout_q  <= dout_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
    end
  end

  assign gnt   = gnt_q;
  assign ack   = ack_q;
  assign busy  = (state_q == StGrant);
  assign dout  = dout_q;
  assign owner = owner_q;

endmodule

// File: doc/reg_share_arbiter.md
Name: reg_share_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 32-bit holding register between N requesters.
- Each requester issues a request with an opcode (load / clear / set / nop) and data.
- The block grants one requester at a time, applies that requester's operation to the register, and returns a one-cycle acknowledge.
- It sits between bus-side clients and the shared data register; `dout` is the register value.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- WIDTH, 32, register and data width.
- SET_VAL, 32'h0000_0001, value written by the SET opcode.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  N_REQ  per-requester request; held high until ack.
- op  input  2*N_REQ  opcode per requester; requester i uses bits [2i+1:2i]. 00 = LOAD, 01 = CLEAR, 10 = SET, 11 = NOP.
- din  input  WIDTH*N_REQ  data per requester; requester i uses bits [WIDTH*i+WIDTH-1:WIDTH*i].
- gnt  output  N_REQ  one-hot grant, or all-zero.
- ack  output  N_REQ  one-hot, one-cycle completion pulse.
- busy  output  1  high while in the GRANT state.
- dout  output  WIDTH  shared register value.
- owner  output  3  index of the last requester that completed an operation.

Behaviour:
- Reset (asynchronous, active-high) forces:
  - state = IDLE;
  - gnt = 0, ack = 0, busy = 0, dout = 0, owner = 0;
  - round-robin pointer ptr = 0.
- Reset mid-operation: the pending op is discarded, no ack is issued, and dout returns to 0.
- FSM has two states: IDLE and GRANT.
- IDLE:
  - eligible = req & ~ack. The requester acked this cycle is masked, so its still-high req cannot be re-granted.
  - If eligible != 0, at the next edge:
    - win = first set bit of eligible, searching from ptr upward, wrapping N_REQ-1 -> 0;
    - gnt = onehot(win), busy = 1, state -> GRANT.
  - If eligible == 0, stay in IDLE with gnt = 0.
- GRANT: at the next edge, if req[win] is still high:
  - dout <= din[win] (LOAD), 0 (CLEAR), SET_VAL (SET), or unchanged (NOP);
  - ack = onehot(win) for exactly one cycle;
  - owner = win;
  - ptr = (win+1) mod N_REQ;
  - gnt = 0, busy = 0, state -> IDLE.
- GRANT abort: if req[win] has dropped, at the next edge:
  - no write, no ack;
  - ptr and owner unchanged;
  - gnt = 0, busy = 0, state -> IDLE.
- Sampling: op and din are sampled only at the completing edge. Changes while gnt is high are legal; the last value before that edge is used.
- Latency:
  - req high at edge E1 -> gnt high from E1;
  - dout updated and ack high from E2;
  - next grant no earlier than E3.
- Throughput: one op per 2 cycles, i.e. a 2-cycle cadence per completed op.
- Other requests arriving while in GRANT wait; there is no preemption.
- Fairness: with all N_REQ requesters continuously requesting, grant order is ptr, ptr+1, … mod N_REQ. No requester waits more than 2*(N_REQ-1) cycles after its request is first eligible.
- ack and gnt are never high in the same cycle.
- gnt is never multi-hot.

Test Plan:
- Reset / single LOAD:
  - assert reset mid-run -> dout = 0, gnt = 0, ack = 0 immediately (asynchronous).
  - Release reset; req = 4'b0001, op0 = 00, din0 = 32'hDEAD_BEEF -> gnt = 0001 after 1 edge, then dout = 32'hDEAD_BEEF, ack = 0001, owner = 0 after the 2nd edge.
- Opcodes on requester 2:
  - CLEAR -> dout = 0;
  - SET -> dout = 32'h0000_0001;
  - NOP -> dout unchanged and ack = 0100 still pulses.
- Round robin, all 4 requesters held high with LOAD and din_i = i+1:
  - grant order 0, 1, 2, 3, 0;
  - dout sequence 1, 2, 3, 4, 1;
  - ack spacing exactly 2 cycles.
- Masking / back-to-back: req0 held high continuously, others idle -> requester 0 is served every 3 cycles. It must not be re-granted in the cycle its ack is high.
- Abort: drop req1 while gnt = 0010 -> no ack, dout unchanged, ptr unchanged. A following req1 is granted first ahead of req2 when both request.
- Reset during GRANT: reset in the GRANT cycle with op = LOAD, din = 32'h1234_5678 -> after release, dout = 0, no ack, and the next arbitration starts from ptr = 0.
